// File: rtl/sdf_ntt_ctrl_param_if.sv
// Handshake and decode bundle between the SDF NTT controller and its frame source / datapath.
// The master drives frame requests and input samples; the slave is the controller.
interface sdf_ntt_ctrl_param_if #(
  parameter int LOG_N = 4
);
  logic                         start;
  logic                         mode;
  logic                         in_valid;
  logic                         in_ready;
  logic                         pipe_ce;
  logic [LOG_N-1:0]             bf_sel;
  logic [LOG_N-1:0]             stage_vld;
  logic [LOG_N*(LOG_N-1)-1:0]   tw_exp;
  logic                         mode_q;
  logic                         out_valid;
  logic [LOG_N-1:0]             out_idx;
  logic                         busy;
  logic                         done;

  modport master (
    output start, mode, in_valid,
    input  in_ready, pipe_ce, bf_sel, stage_vld, tw_exp, mode_q,
           out_valid, out_idx, busy, done
  );

  modport slave (
    input  start, mode, in_valid,
    output in_ready, pipe_ce, bf_sel, stage_vld, tw_exp, mode_q,
           out_valid, out_idx, busy, done
  );
endinterface

// File: rtl/sdf_ntt_ctrl_param.sv
// Frame sequencer for a radix-2 SDF NTT/INTT pipeline: fill under valid/ready, then flush.
// Per-stage selects, twiddle exponents and output tags decode combinationally from state and global count g.
module sdf_ntt_ctrl_param #(
  parameter int LOG_N     = 4,
  parameter int STAGE_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  sdf_ntt_ctrl_param_if.slave bus
);
  localparam int N     = 1 << LOG_N;
  localparam int L_TOT = (N - 1) + LOG_N * STAGE_LAT;
  localparam int CNT_W = $clog2(N + L_TOT);
  localparam int TW_W  = LOG_N - 1;
  localparam logic [CNT_W-1:0] G_FILL_END = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] G_LAST     = CNT_W'(L_TOT + N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_g;
  logic                 r_mode_q;
  logic                 w_ce;
  logic                 w_start_acc;
  logic [31:0]          w_g32;
  logic [LOG_N-1:0]     w_sv;
  logic [LOG_N-1:0]     w_bf;
  logic [LOG_N*TW_W-1:0] w_tw;
  logic                 w_ov;

  // Cycle at which stage s first sees sample 0: sum of upstream delay depths plus inter-stage registers.
  function automatic int stage_off(input int s);
    int acc;
    acc = 0;
    for (int k = 0; k < s; k++) begin
      acc += (N >> (k + 1)) + STAGE_LAT;
    end
    return acc;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_ce        = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        w_ce = bus.in_valid;
        if (w_ce && (r_g == G_FILL_END)) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_ce = 1'b1;
        if (r_g == G_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_g      <= '0;
      r_mode_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_g      <= '0;
        r_mode_q <= bus.mode;
      end else if (w_ce) begin
        r_g <= r_g + CNT_W'(1);
      end
    end
  end

  assign w_g32 = 32'(r_g);

  for (genvar s = 0; s < LOG_N; s++) begin : g_stage
    localparam int OFF = stage_off(s);
    localparam int D   = N >> (s + 1);

    logic [31:0] w_l;
    logic [31:0] w_o;
    logic        w_out_win;

    assign w_l = w_g32 - 32'(OFF);
    assign w_o = w_l - 32'(D);

    assign w_sv[s] = (w_g32 >= 32'(OFF)) && (w_l < 32'(N + D));
    assign w_bf[s] = w_sv[s] && (w_l < 32'(N)) && w_l[LOG_N-1-s];

    // Twiddle applies on the lower half of each butterfly pair leaving the stage.
    assign w_out_win = (w_g32 >= 32'(OFF + D)) && (w_o < 32'(N)) && w_o[LOG_N-1-s];
    assign w_tw[s*TW_W +: TW_W] = w_out_win ? TW_W'((w_o & 32'(D - 1)) << s) : '0;
  end

  assign w_ov = (w_g32 >= 32'(L_TOT)) && (w_g32 < 32'(L_TOT + N));

  assign bus.pipe_ce   = w_ce;
  assign bus.in_ready  = (r_state == S_FILL);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.mode_q    = r_mode_q;
  assign bus.stage_vld = w_ce ? w_sv : '0;
  assign bus.bf_sel    = w_ce ? w_bf : '0;
  assign bus.tw_exp    = w_ce ? w_tw : '0;
  assign bus.out_valid = w_ce && w_ov;
  assign bus.out_idx   = w_ce ? LOG_N'(w_g32 - 32'(L_TOT)) : '0;
  assign bus.done      = w_ce && w_ov && (r_g == G_LAST);
endmodule

// File: tb/tb_sdf_ntt_ctrl_param.sv
// Randomized bench for the SDF NTT controller at (LOG_N,STAGE_LAT) = (4,1) and (5,2),
// scored against a frame-level model built from sample counts and stage timing arithmetic.
module tb_sdf_ntt_ctrl_param;
  logic clk;
  int   n_chk;
  int   n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [63:0] bf;
    logic [63:0] sv;
    logic [63:0] tw;
    logic [63:0] ov;
    logic [63:0] idx;
    logic [63:0] dn;
  } exp_t;

  task automatic chk(input int cfg, input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL cfg%0d %s got=%0h exp=%0h at %0t", cfg, tag, got, exp, $time);
    end
  endtask

  // Expected decode at global time g: sample timing per stage from delay depths and latencies.
  function automatic exp_t ref_decode(input int ln, input int lat, input int g, input bit ce);
    exp_t e;
    int n, lt, off, d, l, o, fw;
    e  = '{default: '0};
    n  = 2 ** ln;
    lt = n - 1 + ln * lat;
    fw = ln - 1;
    if (!ce) return e;
    off = 0;
    for (int s = 0; s < ln; s++) begin
      d = n / (2 ** (s + 1));
      l = g - off;
      if (l >= 0 && l < n + d) begin
        e.sv[s] = 1'b1;
        if (l < n && (l / d) % 2 == 1) e.bf[s] = 1'b1;
      end
      o = l - d;
      if (o >= 0 && o < n && (o / d) % 2 == 1)
        e.tw = e.tw | (64'((o % d) * (2 ** s)) << (s * fw));
      off = off + d + lat;
    end
    e.ov  = 64'(g >= lt && g < lt + n);
    e.idx = 64'(((g - lt) % n + n) % n);
    e.dn  = 64'(g >= lt && g == lt + n - 1);
    return e;
  endfunction

  for (genvar c = 0; c < 2; c++) begin : g_cfg
    localparam int LN = (c == 0) ? 4 : 5;
    localparam int SL = (c == 0) ? 1 : 2;
    localparam int NN = 1 << LN;
    localparam int LT = (NN - 1) + LN * SL;

    logic rst_n;
    bit   fin;

    sdf_ntt_ctrl_param_if #(.LOG_N(LN)) bus ();

    sdf_ntt_ctrl_param #(.LOG_N(LN), .STAGE_LAT(SL)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
    );

    initial begin
      bit   m_act, m_mq, ce;
      int   m_acc, m_fl, g, n_done_exp, n_done_got;
      exp_t e;
      fin          = 1'b0;
      m_act        = 1'b0;
      m_mq         = 1'b0;
      m_acc        = 0;
      m_fl         = 0;
      n_done_exp   = 0;
      n_done_got   = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.mode     = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.start    = ($urandom_range(0, 7) == 0);
        bus.mode     = 1'($urandom_range(0, 1));
        rst_n        = (cyc < 2) || ($urandom_range(0, 299) != 0);
        #3;
        ce = 1'b0;
        g  = 0;
        if (m_act && m_acc < NN) begin
          ce = bus.in_valid;
          g  = m_acc;
        end else if (m_act) begin
          ce = 1'b1;
          g  = NN + m_fl;
        end
        e = ref_decode(LN, SL, g, ce);
        chk(c, "busy",      64'(bus.busy),      64'(m_act));
        chk(c, "in_ready",  64'(bus.in_ready),  64'(m_act && m_acc < NN));
        chk(c, "mode_q",    64'(bus.mode_q),    64'(m_mq));
        chk(c, "pipe_ce",   64'(bus.pipe_ce),   64'(ce));
        chk(c, "stage_vld", 64'(bus.stage_vld), e.sv);
        chk(c, "bf_sel",    64'(bus.bf_sel),    e.bf);
        chk(c, "tw_exp",    64'(bus.tw_exp),    e.tw);
        chk(c, "out_valid", 64'(bus.out_valid), e.ov);
        chk(c, "out_idx",   64'(bus.out_idx),   e.idx);
        chk(c, "done",      64'(bus.done),      e.dn);
        if (e.dn != 0) n_done_exp++;
        if (bus.done) n_done_got++;
        if (!rst_n) begin
          m_act = 1'b0;
          m_acc = 0;
          m_fl  = 0;
          m_mq  = 1'b0;
        end else if (!m_act) begin
          if (bus.start) begin
            m_act = 1'b1;
            m_acc = 0;
            m_fl  = 0;
            m_mq  = bus.mode;
          end
        end else if (m_acc < NN) begin
          if (ce) m_acc++;
        end else begin
          if (g == LT + NN - 1) m_act = 1'b0;
          m_fl++;
        end
        @(posedge clk);
        #1;
      end
      chk(c, "done_count", 64'(n_done_got), 64'(n_done_exp));
      fin = 1'b1;
    end
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    wait (g_cfg[0].fin && g_cfg[1].fin);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog run did not complete");
    $fatal(1, "timeout");
  end
endmodule
